// File: rtl/int_alu_seq.sv
// rtl/int_alu_seq.sv - sequential integer ALU: 1-cycle ADD/SUB/MUL, WIDTH-cycle restoring DIV/REM
module int_alu_seq #(
    parameter int         WIDTH  = 64,
    parameter int         DATA_W = 256,
    parameter logic [3:0] MOD_ID = 4'h5
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic [15:0]       address,
    input  logic [7:0]        opcode,
    input  logic              nWrite,
    input  logic              nRead,
    input  logic [DATA_W-1:0] ExeDataOut,
    output logic [DATA_W-1:0] IntDataOut,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, LOADED, CALC} state_t;

    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_a, r_b, r_quo, r_rem;
    logic [CW-1:0]      r_cnt;
    logic [DATA_W-1:0]  r_result, w_res_val;
    logic               r_done, r_err;
    logic               w_sel, w_wr, w_rd;
    logic               w_load, w_start, w_step, w_res_we, w_err_set, w_clr_ops;
    logic [WIDTH:0]     w_trial, w_diff;
    logic               w_fits;
    logic [WIDTH-1:0]   w_rem_nx, w_quo_nx;
    logic               w_unused_addr;

    assign w_unused_addr = ^address[11:0];
    generate
        if (DATA_W > 2*WIDTH) begin : g_unused
            logic w_unused_hi;
            assign w_unused_hi = ^ExeDataOut[DATA_W-1:2*WIDTH];
        end
    endgenerate

    // A write outranks a simultaneous read, so a read only counts with nWrite high
    assign w_sel = (address[15:12] == MOD_ID);
    assign w_wr  = w_sel & ~nWrite;
    assign w_rd  = w_sel & ~nRead & nWrite;

    // Restoring step: dividend bits shift out of r_quo into the partial remainder
    assign w_trial  = {r_rem, r_quo[WIDTH-1]};
    assign w_diff   = w_trial - {1'b0, r_b};
    assign w_fits   = ~w_diff[WIDTH];
    assign w_rem_nx = w_fits ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_quo_nx = {r_quo[WIDTH-2:0], w_fits};

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_start   = 1'b0;
        w_step    = 1'b0;
        w_res_we  = 1'b0;
        w_res_val = '0;
        w_err_set = 1'b0;
        w_clr_ops = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_wr) begin
                    w_load = 1'b1;
                    w_next = LOADED;
                end
            end
            LOADED: begin
                if (w_wr) begin
                    w_load = 1'b1;
                end else if (w_rd) begin
                    w_next    = IDLE;
                    w_clr_ops = 1'b1;
                    case (opcode)
                        8'h10: begin
                            w_res_we              = 1'b1;
                            w_res_val[WIDTH-1:0]  = r_a + r_b;
                        end
                        8'h11: begin
                            w_res_we              = 1'b1;
                            w_res_val[WIDTH-1:0]  = r_a - r_b;
                        end
                        8'h12: begin
                            w_res_we                = 1'b1;
                            w_res_val[2*WIDTH-1:0]  = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
                        end
                        8'h13, 8'h14: begin
                            if (r_b == '0) begin
                                w_res_we                   = 1'b1;
                                w_err_set                  = 1'b1;
                                w_res_val[WIDTH-1:0]       = '1;
                                w_res_val[2*WIDTH-1:WIDTH] = r_a;
                            end else begin
                                w_start   = 1'b1;
                                w_clr_ops = 1'b0;
                                w_next    = CALC;
                            end
                        end
                        default: w_err_set = 1'b1;
                    endcase
                end
            end
            CALC: begin
                w_step = 1'b1;
                if (r_cnt == '0) begin
                    w_res_we                   = 1'b1;
                    w_res_val[WIDTH-1:0]       = w_quo_nx;
                    w_res_val[2*WIDTH-1:WIDTH] = w_rem_nx;
                    w_clr_ops                  = 1'b1;
                    w_next                     = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= w_res_we;
            if (w_load) begin
                r_a   <= ExeDataOut[WIDTH-1:0];
                r_b   <= ExeDataOut[2*WIDTH-1:WIDTH];
                r_err <= 1'b0;
            end else if (w_clr_ops) begin
                r_a <= '0;
                r_b <= '0;
            end
            if (w_err_set) r_err <= 1'b1;
            if (w_res_we) r_result <= w_res_val;
            if (w_start) begin
                r_quo <= r_a;
                r_rem <= '0;
                r_cnt <= CW'(WIDTH - 1);
            end else if (w_step) begin
                r_quo <= w_quo_nx;
                r_rem <= w_rem_nx;
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    assign IntDataOut = r_result;
    assign busy       = (r_state == CALC);
    assign done       = r_done;
    assign err        = r_err;
endmodule
